// File: rtl/rptr_empty.sv
// Read-domain half of a dual-clock FIFO: binary/Gray read pointer, write-pointer
// synchroniser, and registered empty / almost-empty / fill-level flags.
module rptr_empty #(
   parameter int ADDR_W        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_inc,
   input  logic [ADDR_W:0]   i_writePtr,
   output logic [ADDR_W:0]   o_readPtr,
   output logic [ADDR_W-1:0] o_readAddr,
   output logic              o_empty,
   output logic              o_almostEmpty,
   output logic [ADDR_W:0]   o_level
);

   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] wq;
   logic [PW-1:0] wbin;
   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;
   logic [PW-1:0] gray_d;
   logic [PW-1:0] level_d;
   logic          pop;

   assign wq         = sync_q[SYNC_STAGES-1];
   assign o_readAddr = cnt_q[ADDR_W-1:0];

   // A pop is only honoured while data is visible; requests on empty are dropped.
   assign pop    = i_inc && !o_empty;
   assign cnt_d  = cnt_q + PW'(pop);
   assign gray_d = (cnt_d >> 1) ^ cnt_d;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      wbin = '0;
      for (int i = 0; i < PW; i++) begin
         wbin[i] = ^(wq >> i);
      end
   end

   assign level_d = wbin - cnt_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         cnt_q         <= '0;
         o_readPtr     <= '0;
         o_empty       <= 1'b1;
         o_almostEmpty <= 1'b1;
         o_level       <= '0;
      end else begin
         sync_q[0] <= i_writePtr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         cnt_q         <= cnt_d;
         o_readPtr     <= gray_d;
         // Looking at the next pointer lets the last pop raise empty on its own edge.
         o_empty       <= (gray_d == wq);
         o_almostEmpty <= (level_d <= THRESH);
         o_level       <= level_d;
      end
   end

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: FIFO occupancy model (write count, read count, sampled
// write history) checked against every output after each read-clock edge.
module tb_rptr_empty;

   localparam int AW    = 4;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam int MOD   = 1 << PW;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          i_inc = 1'b0;
   logic [PW-1:0] i_writePtr = '0;
   logic [PW-1:0] o_readPtr;
   logic [AW-1:0] o_readAddr;
   logic          o_empty;
   logic          o_almostEmpty;
   logic [PW-1:0] o_level;

   rptr_empty #(.ADDR_W(AW), .SYNC_STAGES(2), .AEMPTY_THRESH(2)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_inc         (i_inc),
      .i_writePtr    (i_writePtr),
      .o_readPtr     (o_readPtr),
      .o_readAddr    (o_readAddr),
      .o_empty       (o_empty),
      .o_almostEmpty (o_almostEmpty),
      .o_level       (o_level)
   );

   always #5 i_clk = ~i_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: entries written so far (wc), entries read (rd), and the write count
   // as sampled on each read edge; outputs see the sample from two edges back.
   int wc = 0;
   int rd = 0;
   int w_hist[$];
   int m_level = 0;
   bit m_empty = 1'b1;
   bit popped  = 1'b0;

   function automatic logic [PW-1:0] to_gray(input int v);
      logic [PW-1:0] b;
      b = PW'(v % MOD);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      wc = 0;
      rd = 0;
      w_hist = '{0, 0};
      m_level = 0;
      m_empty = 1'b1;
   endtask

   task automatic model_edge();
      int seen;
      popped = i_inc && !m_empty;
      if (popped) rd = (rd + 1) % MOD;
      w_hist.push_back(wc % MOD);
      seen = w_hist[w_hist.size()-3];
      void'(w_hist.pop_front());
      m_level = (seen - rd + MOD) % MOD;
      m_empty = (m_level == 0);
   endtask

   task automatic check_all();
      chk("empty",       int'(o_empty),       int'(m_empty));
      chk("almostEmpty", int'(o_almostEmpty), int'(m_level <= 2));
      chk("level",       int'(o_level),       m_level);
      chk("readPtr",     int'(o_readPtr),     int'(to_gray(rd)));
      chk("readAddr",    int'(o_readAddr),    rd % DEPTH);
   endtask

   // Called from a negedge; drives inputs, advances one read edge, checks.
   task automatic cycle(input logic inc);
      logic [PW-1:0] prev_ptr;
      prev_ptr   = o_readPtr;
      i_inc      = inc;
      i_writePtr = to_gray(wc);
      @(posedge i_clk);
      model_edge();
      #1;
      check_all();
      if (popped) chk("gray_one_bit", $countones(prev_ptr ^ o_readPtr), 1);
      chk("level_max", int'(o_level <= PW'(DEPTH)), 1);
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      #1;
      chk("rst_empty",       int'(o_empty),       1);
      chk("rst_almostEmpty", int'(o_almostEmpty), 1);
      chk("rst_level",       int'(o_level),       0);
      chk("rst_readPtr",     int'(o_readPtr),     0);
      chk("rst_readAddr",    int'(o_readAddr),    0);
      model_reset();
      @(posedge i_clk);
      @(negedge i_clk);
      i_writePtr = '0;
      i_rst = 1'b0;
   endtask

   initial begin
      int pops;
      model_reset();
      @(negedge i_clk);

      // 1: reset with pop requested and a nonzero write pointer present
      i_inc = 1'b1;
      i_writePtr = 5'b00101;
      do_reset();

      // 2: one entry appears after three edges, then a single pop empties it
      wc = 1;
      repeat (3) cycle(1'b0);
      chk("t2_empty_fall", int'(o_empty), 0);
      chk("t2_level1",     int'(o_level), 1);
      cycle(1'b1);
      chk("t2_addr",  int'(o_readAddr), 1);
      chk("t2_ptr",   int'(o_readPtr),  1);
      chk("t2_empty", int'(o_empty),    1);

      // 3: pops requested on an empty FIFO are ignored
      do_reset();
      repeat (5) cycle(1'b1);
      chk("t3_ptr",   int'(o_readPtr), 0);
      chk("t3_empty", int'(o_empty),   1);

      // 4: full FIFO, drain to the almost-empty threshold, then to empty
      do_reset();
      wc = 16;
      repeat (3) cycle(1'b0);
      chk("t4_level16", int'(o_level),       16);
      chk("t4_ae0",     int'(o_almostEmpty), 0);
      repeat (14) cycle(1'b1);
      chk("t4_level2",  int'(o_level),       2);
      chk("t4_ae1",     int'(o_almostEmpty), 1);
      repeat (2) cycle(1'b1);
      chk("t4_empty",   int'(o_empty),       1);
      chk("t4_ptr",     int'(o_readPtr),     5'b11000);
      chk("t4_addr",    int'(o_readAddr),    0);

      // 5: random concurrent writes and reads, past the pointer wrap
      do_reset();
      pops = 0;
      for (int k = 0; k < 600 && pops < 48; k++) begin
         if ((wc - rd) < DEPTH && $urandom_range(0, 3) != 0) wc++;
         cycle(logic'($urandom_range(0, 2) != 0));
         if (popped) pops++;
      end
      chk("t5_enough_pops", int'(pops >= 40), 1);

      // 6: reset mid-burst at level 7, then resume only with a fresh pointer
      do_reset();
      wc = 7;
      repeat (3) cycle(1'b0);
      chk("t6_level7", int'(o_level), 7);
      cycle(1'b1);
      do_reset();
      repeat (3) cycle(1'b1);
      chk("t6_still_empty", int'(o_empty), 1);
      wc = 3;
      repeat (3) cycle(1'b0);
      chk("t6_fresh_level", int'(o_level), 3);
      repeat (4) cycle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
